// File: rtl/pci_burst_write_sequencer.sv
// PCI master write sequencer: address phase, data phases, target termination and master abort.
// Optional PAR/PAR_OE outputs are built when PCI_PARITY_EN is defined.
module pci_burst_write_sequencer #(
  parameter int LINE_WORDS     = 4,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic        PCICLK,
  input  logic        nRESET,
  input  logic        START,
  input  logic [31:0] ADDR,
  input  logic        LINE,
  input  logic [31:0] BUF_DATA,
  input  logic        BUF_VALID,
  output logic        BUF_POP,
  input  logic        nTRDY,
  input  logic        nSTOP,
  input  logic        nDEVSEL,
  output logic [31:0] AD_OUT,
  output logic [3:0]  CBE_OUT,
  output logic        AD_OE,
  output logic        nFRAME,
  output logic        nIRDY,
  output logic        BUSY,
  output logic        DONE,
  output logic        RETRY,
  output logic        ABORT
`ifdef PCI_PARITY_EN
  ,
  output logic        PAR,
  output logic        PAR_OE
`endif
);

  localparam int CW = $clog2(LINE_WORDS) + 1;
  localparam int TW = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_END,
    S_TURN
  } state_t;

  typedef enum logic [1:0] {
    RES_DONE,
    RES_RETRY,
    RES_ABORT
  } result_t;

  state_t          r_state;
  state_t          w_state_next;
  result_t         r_result;
  result_t         w_result_next;
  logic [31:0]     r_addr;
  logic [31:0]     w_addr_next;
  logic [CW-1:0]   r_remaining;
  logic [CW-1:0]   w_remaining_next;
  logic [CW-1:0]   r_xfers;
  logic [CW-1:0]   w_xfers_next;
  logic [TW-1:0]   r_dev_cnt;
  logic [TW-1:0]   w_dev_cnt_next;
  logic [TW-1:0]   w_dev_inc;
  logic            r_irdy_held;
  logic            w_irdy_held_next;

  logic            w_irdy;
  logic            w_last;
  logic            w_abort;
  logic            w_xfer;

  // IRDY# asserts as soon as the buffer has a word and is then held until the word moves.
  assign w_irdy    = (r_state == S_DATA) && (r_irdy_held || BUF_VALID);
  assign w_last    = w_irdy && (r_remaining == CW'(1));
  assign w_dev_inc = (r_dev_cnt == TW'(DEVSEL_TIMEOUT)) ? r_dev_cnt : r_dev_cnt + TW'(1);
  assign w_abort   = (r_state == S_DATA) && nDEVSEL && (w_dev_inc == TW'(DEVSEL_TIMEOUT));
  assign w_xfer    = w_irdy && !nTRDY && !w_abort;

  always_ff @(posedge PCICLK) begin
    if (!nRESET) begin
      r_state     <= S_IDLE;
      r_result    <= RES_DONE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_xfers     <= '0;
      r_dev_cnt   <= '0;
      r_irdy_held <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_result    <= w_result_next;
      r_addr      <= w_addr_next;
      r_remaining <= w_remaining_next;
      r_xfers     <= w_xfers_next;
      r_dev_cnt   <= w_dev_cnt_next;
      r_irdy_held <= w_irdy_held_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_result_next    = r_result;
    w_addr_next      = r_addr;
    w_remaining_next = r_remaining;
    w_xfers_next     = r_xfers;
    w_dev_cnt_next   = r_dev_cnt;
    w_irdy_held_next = r_irdy_held;

    AD_OUT  = 32'h0;
    CBE_OUT = 4'b0000;
    AD_OE   = 1'b0;
    nFRAME  = 1'b1;
    nIRDY   = 1'b1;
    BUF_POP = 1'b0;
    DONE    = 1'b0;
    RETRY   = 1'b0;
    ABORT   = 1'b0;
    BUSY    = (r_state != S_IDLE);

    unique case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_next     = S_ADDR;
          w_addr_next      = ADDR;
          w_remaining_next = LINE ? CW'(LINE_WORDS) : CW'(1);
          w_xfers_next     = '0;
          w_irdy_held_next = 1'b0;
        end
      end

      S_ADDR: begin
        nFRAME         = 1'b0;
        AD_OE          = 1'b1;
        AD_OUT         = r_addr;
        CBE_OUT        = 4'b0111;
        w_dev_cnt_next = '0;
        w_state_next   = S_DATA;
      end

      S_DATA: begin
        AD_OE   = 1'b1;
        AD_OUT  = BUF_DATA;
        CBE_OUT = 4'b0000;
        nIRDY   = !w_irdy;
        nFRAME  = w_last;
        BUF_POP = w_xfer;

        if (nDEVSEL) begin
          w_dev_cnt_next = w_dev_inc;
        end
        if (w_xfer) begin
          w_remaining_next = r_remaining - CW'(1);
          w_xfers_next     = r_xfers + CW'(1);
        end
        w_irdy_held_next = w_irdy && !w_xfer;

        // A final-word transfer wins over a simultaneous STOP#.
        if (w_abort) begin
          w_state_next  = S_END;
          w_result_next = RES_ABORT;
        end else if (w_xfer && (r_remaining == CW'(1))) begin
          w_state_next  = S_TURN;
          w_result_next = RES_DONE;
        end else if (!nSTOP) begin
          w_result_next = (w_xfer || (r_xfers != '0)) ? RES_DONE : RES_RETRY;
          w_state_next  = w_last ? S_TURN : S_END;
        end
      end

      S_END: begin
        AD_OE        = 1'b1;
        AD_OUT       = BUF_DATA;
        CBE_OUT      = 4'b0000;
        nFRAME       = 1'b1;
        nIRDY        = 1'b0;
        w_state_next = S_TURN;
      end

      S_TURN: begin
        DONE         = (r_result == RES_DONE);
        RETRY        = (r_result == RES_RETRY);
        ABORT        = (r_result == RES_ABORT);
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

`ifdef PCI_PARITY_EN
  logic r_par;
  logic r_par_oe;

  // PAR trails the AD/C/BE# phase it covers by one clock.
  always_ff @(posedge PCICLK) begin
    if (!nRESET) begin
      r_par    <= 1'b0;
      r_par_oe <= 1'b0;
    end else begin
      r_par    <= ^{AD_OUT, CBE_OUT};
      r_par_oe <= AD_OE;
    end
  end

  assign PAR    = r_par;
  assign PAR_OE = r_par_oe;
`endif

endmodule

// File: tb/tb_pci_burst_write_sequencer.sv
// Directed and randomized transactions against a cycle-by-cycle reference built from the PCI write rules.
module tb_pci_burst_write_sequencer;

  logic        PCICLK = 1'b0;
  logic        nRESET;
  logic        START;
  logic [31:0] ADDR;
  logic        LINE;
  logic [31:0] BUF_DATA;
  logic        BUF_VALID;
  logic        BUF_POP;
  logic        nTRDY;
  logic        nSTOP;
  logic        nDEVSEL;
  logic [31:0] AD_OUT;
  logic [3:0]  CBE_OUT;
  logic        AD_OE;
  logic        nFRAME;
  logic        nIRDY;
  logic        BUSY;
  logic        DONE;
  logic        RETRY;
  logic        ABORT;
`ifdef PCI_PARITY_EN
  logic        PAR;
  logic        PAR_OE;
`endif

  int checks = 0;
  int errors = 0;

  bit tv_valid   [64];
  bit tv_trdy_n  [64];
  bit tv_stop_n  [64];
  bit tv_devsel_n[64];
  logic [31:0] buf_q[$];

  always #5 PCICLK = ~PCICLK;

  pci_burst_write_sequencer #(.LINE_WORDS(4), .DEVSEL_TIMEOUT(5)) dut (
    .PCICLK(PCICLK), .nRESET(nRESET), .START(START), .ADDR(ADDR), .LINE(LINE),
    .BUF_DATA(BUF_DATA), .BUF_VALID(BUF_VALID), .BUF_POP(BUF_POP),
    .nTRDY(nTRDY), .nSTOP(nSTOP), .nDEVSEL(nDEVSEL),
    .AD_OUT(AD_OUT), .CBE_OUT(CBE_OUT), .AD_OE(AD_OE), .nFRAME(nFRAME), .nIRDY(nIRDY),
    .BUSY(BUSY), .DONE(DONE), .RETRY(RETRY), .ABORT(ABORT)
`ifdef PCI_PARITY_EN
    , .PAR(PAR), .PAR_OE(PAR_OE)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCICLK);
    #1;
  endtask

  task automatic idle_inputs();
    START     = 1'b0;
    BUF_VALID = 1'b0;
    BUF_DATA  = 32'h0;
    nTRDY     = 1'b1;
    nSTOP     = 1'b1;
    nDEVSEL   = 1'b1;
  endtask

  task automatic set_tables(input bit v, input bit t, input bit s, input bit d);
    for (int k = 0; k < 64; k++) begin
      tv_valid[k]    = v;
      tv_trdy_n[k]   = t;
      tv_stop_n[k]   = s;
      tv_devsel_n[k] = d;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_frame"}, nFRAME, 1'b1);
    chk({tag, "_irdy"},  nIRDY,  1'b1);
    chk({tag, "_oe"},    AD_OE,  1'b0);
    chk({tag, "_busy"},  BUSY,   1'b0);
    chk({tag, "_pop"},   BUF_POP, 1'b0);
    chk({tag, "_res"},   {DONE, RETRY, ABORT}, 3'b000);
  endtask

  task automatic pulse_reset();
    tick();
    idle_inputs();
    nRESET = 1'b0;
    tick();
    nRESET = 1'b1;
    @(negedge PCICLK);
    buf_q.delete();
  endtask

  // res: 1 = DONE, 2 = RETRY, 3 = ABORT
  task automatic run_txn(input string name, input logic [31:0] addr, input logic line,
                         input int rst_after, output bit rst_hit);
    int   left, xfers, dev_miss, res, k;
    bit   committed, irdy, last_ph, xfer, abort_now, finished, end_cyc;
    logic [31:0] head;
    rst_hit   = 1'b0;
    left      = line ? 4 : 1;
    xfers     = 0;
    dev_miss  = 0;
    res       = 0;
    committed = 1'b0;
    finished  = 1'b0;
    end_cyc   = 1'b0;

    tick();
    idle_inputs();
    START = 1'b1;
    ADDR  = addr;
    LINE  = line;
    @(negedge PCICLK);
    chk({name, "_idle_busy"}, BUSY, 1'b0);

    tick();
    START = 1'b0;
    ADDR  = $urandom;
    LINE  = 1'($urandom);
    @(negedge PCICLK);
    chk({name, "_addr_ad"},    AD_OUT, addr);
    chk({name, "_addr_cbe"},   CBE_OUT, 4'b0111);
    chk({name, "_addr_frame"}, nFRAME, 1'b0);
    chk({name, "_addr_irdy"},  nIRDY, 1'b1);
    chk({name, "_addr_oe"},    AD_OE, 1'b1);
    chk({name, "_addr_busy"},  BUSY, 1'b1);

    k = 0;
    while (!finished && k < 60) begin
      tick();
      head      = (buf_q.size() > 0) ? buf_q[0] : 32'h0;
      BUF_DATA  = head;
      BUF_VALID = tv_valid[k] && (buf_q.size() > 0);
      nTRDY     = tv_trdy_n[k];
      nSTOP     = tv_stop_n[k];
      nDEVSEL   = tv_devsel_n[k];
      @(negedge PCICLK);

      irdy = committed || BUF_VALID;
      if (tv_devsel_n[k]) dev_miss++;
      abort_now = tv_devsel_n[k] && (dev_miss == 5);
      xfer      = irdy && !tv_trdy_n[k] && !abort_now;
      last_ph   = irdy && (left == 1);

      chk({name, "_data_irdy"},  nIRDY, !irdy);
      chk({name, "_data_frame"}, nFRAME, last_ph);
      chk({name, "_data_ad"},    AD_OUT, head);
      chk({name, "_data_cbe"},   CBE_OUT, 4'b0000);
      chk({name, "_data_pop"},   BUF_POP, xfer);
      chk({name, "_data_oe"},    AD_OE, 1'b1);
      chk({name, "_data_res"},   {DONE, RETRY, ABORT, BUSY}, 4'b0001);

      if (xfer) void'(buf_q.pop_front());

      if (abort_now) begin
        res = 3; end_cyc = 1'b1; finished = 1'b1;
      end else if (xfer && left == 1) begin
        res = 1; finished = 1'b1;
      end else if (!tv_stop_n[k]) begin
        res      = (xfer || xfers > 0) ? 1 : 2;
        end_cyc  = !last_ph;
        finished = 1'b1;
      end else if (xfer) begin
        left--;
        xfers++;
        committed = 1'b0;
        if (rst_after > 0 && xfers == rst_after) begin
          rst_hit  = 1'b1;
          finished = 1'b1;
        end
      end else begin
        committed = irdy;
      end
      k++;
    end

    chk({name, "_bounded"}, finished, 1'b1);
    if (!finished) begin
      pulse_reset();
      return;
    end
    if (rst_hit) return;

    if (end_cyc) begin
      tick();
      idle_inputs();
      @(negedge PCICLK);
      chk({name, "_end_frame"}, nFRAME, 1'b1);
      chk({name, "_end_irdy"},  nIRDY, 1'b0);
      chk({name, "_end_pop"},   BUF_POP, 1'b0);
      chk({name, "_end_res"},   {DONE, RETRY, ABORT, BUSY}, 4'b0001);
    end

    tick();
    idle_inputs();
    @(negedge PCICLK);
    chk({name, "_turn_frame"}, nFRAME, 1'b1);
    chk({name, "_turn_irdy"},  nIRDY, 1'b1);
    chk({name, "_turn_oe"},    AD_OE, 1'b0);
    chk({name, "_turn_pop"},   BUF_POP, 1'b0);
    chk({name, "_turn_res"},   {DONE, RETRY, ABORT, BUSY},
        {res == 1, res == 2, res == 3, 1'b1});

    tick();
    @(negedge PCICLK);
    chk_quiet({name, "_after"});
    buf_q.delete();
  endtask

  initial begin
    bit h;
    nRESET = 1'b0;
    ADDR   = 32'h0;
    LINE   = 1'b0;
    idle_inputs();

    tick();
    tick();
    @(negedge PCICLK);
    chk_quiet("reset");
    chk("reset_ad",  AD_OUT, 32'h0);
    chk("reset_cbe", CBE_OUT, 4'h0);
    nRESET = 1'b1;

    set_tables(1, 0, 1, 0);
    buf_q = '{32'hffff0000, 32'heeee1111, 32'hdddd2222, 32'hcccc3333};
    run_txn("line", 32'h4000_0010, 1'b1, 0, h);
    $display("txn line zero-wait done, checks=%0d errors=%0d", checks, errors);

    set_tables(1, 0, 1, 0);
    tv_trdy_n[2] = 1; tv_trdy_n[3] = 1;
    buf_q = '{32'hffff0000, 32'heeee1111, 32'hdddd2222, 32'hcccc3333};
    run_txn("twait", 32'h4000_0010, 1'b1, 0, h);
    $display("txn target-wait done, checks=%0d errors=%0d", checks, errors);

    set_tables(1, 0, 1, 0);
    tv_valid[1] = 0; tv_valid[2] = 0; tv_valid[3] = 0;
    buf_q = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
    run_txn("underrun", 32'h8000_0040, 1'b1, 0, h);
    $display("txn underrun done, checks=%0d errors=%0d", checks, errors);

    set_tables(1, 0, 1, 0);
    tv_stop_n[0] = 0; tv_trdy_n[0] = 1;
    buf_q = '{32'ha1, 32'ha2, 32'ha3, 32'ha4};
    run_txn("retry", 32'h0000_1000, 1'b1, 0, h);
    $display("txn retry done, checks=%0d errors=%0d", checks, errors);

    set_tables(1, 1, 1, 1);
    buf_q = '{32'hb1, 32'hb2, 32'hb3, 32'hb4};
    run_txn("mabort", 32'h0000_2000, 1'b1, 0, h);
    $display("txn master-abort done, checks=%0d errors=%0d", checks, errors);

    set_tables(1, 0, 1, 0);
    buf_q = '{32'hcafe_f00d};
    run_txn("single", 32'h1234_5678, 1'b0, 0, h);
    $display("txn single done, checks=%0d errors=%0d", checks, errors);

    set_tables(1, 0, 1, 0);
    tv_stop_n[0] = 0; tv_trdy_n[0] = 1;
    buf_q = '{32'hdead_beef};
    run_txn("retry1", 32'h1234_0000, 1'b0, 0, h);
    $display("txn single-retry done, checks=%0d errors=%0d", checks, errors);

    set_tables(1, 0, 1, 0);
    tv_stop_n[1] = 0;
    buf_q = '{32'hc1, 32'hc2, 32'hc3, 32'hc4};
    run_txn("disc_data", 32'h0000_3000, 1'b1, 0, h);
    $display("txn disconnect-with-data done, checks=%0d errors=%0d", checks, errors);

    set_tables(1, 0, 1, 0);
    tv_stop_n[1] = 0; tv_trdy_n[1] = 1;
    buf_q = '{32'hd1, 32'hd2, 32'hd3, 32'hd4};
    run_txn("disc_nodata", 32'h0000_4000, 1'b1, 0, h);
    $display("txn disconnect-without-data done, checks=%0d errors=%0d", checks, errors);

    set_tables(1, 0, 1, 0);
    tv_stop_n[3] = 0;
    buf_q = '{32'he1, 32'he2, 32'he3, 32'he4};
    run_txn("stop_last", 32'h0000_5000, 1'b1, 0, h);
    $display("txn stop-on-final done, checks=%0d errors=%0d", checks, errors);

    set_tables(1, 0, 1, 0);
    buf_q = '{32'hf1, 32'hf2, 32'hf3, 32'hf4};
    run_txn("rst_mid", 32'h0000_6000, 1'b1, 2, h);
    chk("rst_mid_hit", h, 1'b1);
    pulse_reset();
    chk_quiet("rst_mid_after");
    set_tables(1, 0, 1, 0);
    buf_q = '{32'h0a0a0a0a, 32'h0b0b0b0b, 32'h0c0c0c0c, 32'h0d0d0d0d};
    run_txn("post_rst", 32'h0000_7000, 1'b1, 0, h);
    $display("txn reset-mid-burst done, checks=%0d errors=%0d", checks, errors);

    for (int t = 0; t < 40; t++) begin
      bit ln;
      int d;
      ln = 1'($urandom);
      d  = ($urandom % 6 == 0) ? int'($urandom_range(0, 6)) : 0;
      for (int k = 0; k < 64; k++) begin
        tv_valid[k]    = ($urandom % 4) != 0;
        tv_trdy_n[k]   = ($urandom % 10) < 3;
        tv_stop_n[k]   = ($urandom % 20) != 0;
        tv_devsel_n[k] = 1'b0;
        if (k < d) begin
          tv_devsel_n[k] = 1'b1;
          tv_trdy_n[k]   = 1'b1;
          tv_stop_n[k]   = 1'b1;
        end
      end
      for (int w = 0; w < (ln ? 4 : 1); w++) buf_q.push_back($urandom);
      run_txn("rand", $urandom & 32'hffff_fffc, ln, 0, h);
      $display("txn rand %0d line=%0b devsel_delay=%0d, checks=%0d errors=%0d",
               t, ln, d, checks, errors);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
